// File: rtl/serial_sub16.sv
// Bit-serial subtractor: captures a, b and bin, then produces (a - b - bin) one bit
// per cycle, LSB first. Defining SUB_OVF_EN adds the registered signed-overflow port ovf.
module serial_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    // Handshakes: an operand transfer happens on an edge where in_valid && in_ready;
    // a result transfer happens on an edge where out_valid && out_ready. Neither
    // valid depends combinationally on the matching ready.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_out_valid;
    logic             r_in_ready;
`ifdef SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    logic w_ai;
    logic w_bi;
    logic w_d;
    logic w_br_next;

    // Operand registers shift right, so bit 0 is always the bit being processed.
    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_d       = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~w_ai & r_br) | (w_bi & r_br);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_br        <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef SUB_OVF_EN
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_br       <= bin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
`ifdef SUB_OVF_EN
                        r_a_msb    <= a[WIDTH-1];
                        r_b_msb    <= b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_br_next;
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_bout      <= w_br_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
`ifdef SUB_OVF_EN
                        r_ovf       <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign dbg_state = r_state;
`ifdef SUB_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub16.sv
// Bench for serial_sub16: directed vector table, handshake/reset sequences and
// randomized operands checked against an arithmetic model.
module tb_serial_sub16;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  diff;
    logic          bout;
    logic [1:0]    dbg_state;
`ifdef SUB_OVF_EN
    logic          ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_sub16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
`ifdef SUB_OVF_EN
        .ovf       (ovf),
`endif
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference from plain integer arithmetic; ovf is the sign rule on the operand and result MSBs.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] md, output logic mbo, output logic mov);
        int full;
        full = int'({16'b0, ma}) - int'({16'b0, mb}) - int'({31'b0, mbin});
        md   = full[W-1:0];
        mbo  = (full < 0);
        mov  = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
    endtask

    task automatic get_ovf(output logic o);
`ifdef SUB_OVF_EN
        o = ovf;
`else
        o = 1'b0;
`endif
    endtask

    // Runs one operation; noisy keeps in_valid high with junk operands while busy.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                          input int hold, input bit noisy,
                          output logic [W-1:0] rdiff, output logic rbout, output logic rovf);
        int  t;
        int  lat;
        bit  got;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        a = ia; b = ib; bin = ibin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = noisy;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) check("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_valid) got = 1;
            else if (noisy) begin
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'(W));
        rdiff = diff;
        rbout = bout;
        get_ovf(rovf);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_diff", 32'(diff), 32'(rdiff));
            check("hold_bout", 32'(bout), 32'(rbout));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t         vecs[6];
    logic [W-1:0] rd;
    logic         rb;
    logic         ro;
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    bit           spurious;

    initial begin
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 5};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].hold, 1'b0, rd, rb, ro);
            check("vec_diff", 32'(rd), 32'(vecs[i].diff));
            check("vec_bout", 32'(rb), 32'(vecs[i].bout));
`ifdef SUB_OVF_EN
            check("vec_ovf", 32'(ro), 32'(vecs[i].ovf));
`endif
        end

        // New operands offered during RUN and DONE must be dropped, with no second result.
        run_op(16'h1234, 16'h0234, 1'b0, 2, 1'b1, rd, rb, ro);
        check("noisy_diff", 32'(rd), 32'h1000);
        check("noisy_bout", 32'(rb), 32'd0);
        spurious = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) spurious = 1;
        end
        check("no_second_result", 32'(spurious), 32'd0);

        // Reset while RUN is on bit 8.
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_state", 32'(dbg_state), 32'd0);
        run_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0, rd, rb, ro);
        check("post_rst_diff", 32'(rd), 32'h0002);
        check("post_rst_bout", 32'(rb), 32'd0);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rbv;
            logic         rbin;
            ra   = W'($urandom);
            rbv  = W'($urandom);
            rbin = 1'($urandom);
            if (i < 3) rbv = ra;
            model(ra, rbv, rbin, ed, eb, eo);
            run_op(ra, rbv, rbin, $urandom_range(0, 3), 1'($urandom), rd, rb, ro);
            check("rand_diff", 32'(rd), 32'(ed));
            check("rand_bout", 32'(rb), 32'(eb));
`ifdef SUB_OVF_EN
            check("rand_ovf", 32'(ro), 32'(eo));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sub16.md
SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 The block SHALL have one parameter: WIDTH, 16, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have these ports, one clock and one reset; reset is synchronous and active-high:
  clk        input   1      sole clock, rising edge
  rst        input   1      synchronous active-high reset
  in_valid   input   1      operands present
  in_ready   output  1      block can accept operands
  a          input   WIDTH  minuend
  b          input   WIDTH  subtrahend
  bin        input   1      borrow in
  out_valid  output  1      result present
  out_ready  input   1      consumer accepts result
  diff       output  WIDTH  (a - b - bin) mod 2^WIDTH
  bout       output  1      borrow out
  ovf        output  1      signed overflow (present only with SUB_OVF_EN)

Function
REQ-003 The block SHALL use a 3-state FSM: IDLE, RUN, DONE.
REQ-004 IDLE: in_ready=1 and out_valid=0; on in_valid=1 it SHALL capture a, b and bin, clear the bit counter, and go to RUN.
REQ-005 After capture, later changes on a, b and bin SHALL have no effect on the current operation.
REQ-006 RUN: in_ready=0; each cycle SHALL process one bit, LSB first, for exactly WIDTH cycles.
REQ-007 Per-bit rule: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br); br starts at the captured bin.
REQ-008 After the WIDTH-th bit the FSM SHALL go to DONE. out_valid SHALL first be high WIDTH cycles after the accepting edge (16 for the default).
REQ-009 DONE: out_valid=1; diff and bout (and ovf) SHALL be the final values and stay stable while out_ready=0.
REQ-010 DONE with out_ready=1: the FSM SHALL return to IDLE on that edge. in_ready SHALL rise the following cycle; a same-cycle new accept is not allowed.
REQ-011 bout SHALL be 1 iff unsigned a < b + bin.
REQ-012 in_valid outside IDLE SHALL be ignored; no queuing.
REQ-013 diff, bout and ovf SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-014 With rst=1 at a rising edge: FSM to IDLE, counter=0, diff=0, bout=0, ovf=0, out_valid=0, in_ready=1 the next cycle.
REQ-015 Reset asserted in RUN or DONE SHALL abandon the operation with no result emitted.
REQ-016 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-017 The macro SUB_OVF_EN SHALL select the overflow feature.
- Defined: port ovf exists; ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), with bin included in diff; registered with diff.
- Undefined: port ovf and its logic are absent; all other behaviour is unchanged.

Verification
REQ-018 a=0x1234, b=0x0234, bin=0, accepted at edge E0 -> out_valid at E16: diff=0x1000, bout=0, ovf=0.
REQ-019 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Separately, a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1.
REQ-020 With SUB_OVF_EN defined: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Undefined -> same diff/bout, no ovf port.
REQ-021 out_ready held 0 for 5 cycles in DONE -> diff, bout and out_valid hold. out_ready=1 -> IDLE, then in_ready=1 on the next cycle.
REQ-022 in_valid=1 with new operands during RUN -> ignored; the first result is unchanged and no second result appears.
REQ-023 rst=1 at RUN bit 8 -> next cycle out_valid=0, diff=0, in_ready=1. A fresh a=0x0005, b=0x0003 -> diff=0x0002 after 16 cycles.
